// File: rtl/receiver_pkg.sv
// Shared types and constants for the oversampling serial receiver.
// Build option: define RECEIVER_PARITY_EN to compile in the parity bit and check.
package receiver_pkg;

  // Receiver FSM states. PARITY only exists when the parity bit is compiled in.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef RECEIVER_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  // Parity sense selectors for the PARITY_ODD parameter.
  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the serial receiver. Counts clk cycles within one bit
// period and flags the half-bit point (start-bit centre) and the last cycle of
// a full bit period (centre of data/parity/stop bits once re-aligned).
module rx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic mid_tick,
  output logic full_tick
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_CNT = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] cnt;

  // Counter: clear wins, otherwise count and restart after a full bit period
  // (OVERSAMPLE need not be a power of two, so the wrap is explicit).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == FULL_CNT) cnt <= '0;
      else                 cnt <= cnt + TW'(1);
    end
  end

  assign mid_tick  = (cnt == MID_CNT);
  assign full_tick = (cnt == FULL_CNT);

endmodule

// File: rtl/receiver_param.sv
// Oversampling asynchronous serial receiver (start, DATA_BITS LSB-first,
// optional parity, stop). The line is resynchronised, the start bit is
// qualified at its centre, and every later bit is sampled one full bit period
// after the previous sample point.
// Build option: RECEIVER_PARITY_EN adds the parity bit, PARITY state and the
// parity_error report; without it parity_error is tied low.
module receiver_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 read_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 character_received,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  import receiver_pkg::*;

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 fall;
  rx_state_e            state;
  rx_state_e            state_n;
  logic                 tmr_clear;
  logic                 tmr_en;
  logic                 mid_tick;
  logic                 full_tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 data_sample;
  logic                 stop_sample;
  logic                 good_stop;

  // Two-flop synchronizer (idle-high reset) plus a delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], data_in};
      rx_prev <= sync[1];
    end
  end

  assign rx_s = sync[1];
  assign fall = rx_prev & ~rx_s;

  rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (tmr_clear),
    .en        (tmr_en),
    .mid_tick  (mid_tick),
    .full_tick (full_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (fall) state_n = START;
      // Start bit must still be low at its centre, otherwise it was a glitch.
      START:     if (mid_tick) state_n = rx_s ? IDLE : DATA;
      DATA: begin
        if (full_tick && (bit_cnt == LAST_BIT)) begin
`ifdef RECEIVER_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef RECEIVER_PARITY_EN
      PARITY:    if (full_tick) state_n = STOP;
`endif
      // A low stop bit means we may be mid-break: wait for the line to idle.
      STOP:      if (full_tick) state_n = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // FSM outputs: timer control and sample strobes.
  always_comb begin
    busy        = (state != IDLE);
    tmr_en      = (state != IDLE);
    // Timer is held at zero while idle so the IDLE->START edge starts it from 0;
    // it is re-zeroed at the start-bit centre to align later samples.
    tmr_clear   = (state == IDLE) || (state == WAIT_IDLE) ||
                  ((state == START) && mid_tick);
    data_sample = (state == DATA) && full_tick;
    stop_sample = (state == STOP) && full_tick;
  end

  // Data shift register (LSB arrives first, so shift towards bit 0) and bit count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == START) begin
      bit_cnt <= '0;
    end else if (data_sample) begin
      shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

`ifdef RECEIVER_PARITY_EN
  logic par_exp;

  // Expected parity bit: XOR of the data, inverted for odd parity.
  assign par_exp = (^shreg) ^ (PARITY_ODD != int'(PARITY_EVEN));

  // Pending parity error, reported only once the stop bit proves the frame sound.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err <= 1'b0;
    end else if (state == START) begin
      par_err <= 1'b0;
    end else if ((state == PARITY) && full_tick) begin
      par_err <= rx_s ^ par_exp;
    end
  end

  // Parity error pulse (suppressed by a framing error).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_error <= 1'b0;
    else      parity_error <= stop_sample && rx_s && par_err;
  end
`else
  logic unused_cfg;

  assign par_err      = 1'b0;
  assign parity_error = 1'b0;
  assign unused_cfg   = ^PARITY_ODD;
`endif

  assign good_stop = stop_sample && rx_s && !par_err;

  // Result registers: pulses, held character and consumer handshake flags.
  // A completing character beats a same-cycle read_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out           <= '0;
      character_received <= 1'b0;
      framing_error      <= 1'b0;
      data_valid         <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      character_received <= good_stop;
      framing_error      <= stop_sample && !rx_s;
      if (good_stop) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
        if (data_valid && !read_ack) overrun <= 1'b1;
        else if (read_ack)           overrun <= 1'b0;
      end else if (read_ack && !character_received) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receiver_param.sv
// Self-checking bench for receiver_param: directed frames followed by random
// frames, checked against a frame-level reference model.
module tb_receiver_param;

  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam int PODD = 0;
`ifdef RECEIVER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Cycles from the edge-detect cycle to the character_received pulse.
  localparam int LAT = OS/2 + OS*(DB + 1 + P) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_in = 1'b1;
  logic          read_ack = 1'b0;
  logic [DB-1:0] data_out;
  logic          character_received, data_valid, framing_error;
  logic          parity_error, overrun, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_char = 0, n_frm = 0, n_par = 0, last_char_cyc = -1;

  receiver_param #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .PARITY_ODD (PODD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .data_in            (data_in),
    .read_ack           (read_ack),
    .data_out           (data_out),
    .character_received (character_received),
    .data_valid         (data_valid),
    .framing_error      (framing_error),
    .parity_error       (parity_error),
    .overrun            (overrun),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (character_received) begin
      n_char        <= n_char + 1;
      last_char_cyc <= cyc;
    end
    if (framing_error) n_frm <= n_frm + 1;
    if (parity_error)  n_par <= n_par + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic gpar(input logic [DB-1:0] d);
    return (^d) ^ (PODD != 0);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_for(input logic b);
    data_in = b;
    tick(OS);
  endtask

  task automatic idle(input int n);
    data_in = 1'b1;
    tick(n);
  endtask

  task automatic ack();
    read_ack = 1'b1;
    tick(1);
    read_ack = 1'b0;
  endtask

  // Drives one full frame; k returns the cycle at which the start bit was driven.
  task automatic send_frame(input logic [DB-1:0] d, input logic pbit,
                            input logic sbit, output int k);
    k = cyc;
    bit_for(1'b0);
    for (int i = 0; i < DB; i++) bit_for(d[i]);
    if (P != 0) bit_for(pbit);
    bit_for(sbit);
  endtask

  initial begin
    int k, c0, f0, p0;
    logic [DB-1:0] m_do, d;
    logic m_dv, m_ov, bad_par, bad_stop, good;

    // Reset state
    tick(3);
    chk("rst_data_out", data_out, 0);
    chk("rst_char", character_received, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_frm", framing_error, 0);
    chk("rst_par", parity_error, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    idle(10);

    // Good character 0xA5 with latency check
    c0 = n_char; f0 = n_frm; p0 = n_par;
    send_frame(8'hA5, gpar(8'hA5), 1'b1, k);
    idle(4);
    chk("a5_char_cnt", n_char - c0, 1);
    chk("a5_latency", last_char_cyc, k + 2 + LAT);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_valid", data_valid, 1);
    chk("a5_errs", (n_frm - f0) + (n_par - p0), 0);
    ack();
    chk("a5_ack_valid", data_valid, 0);

    // Start-bit glitch: 5 cycles low
    c0 = n_char; f0 = n_frm; p0 = n_par;
    k = cyc;
    data_in = 1'b0;
    tick(5);
    data_in = 1'b1;
    chk("glitch_busy_hi", busy, 1);
    tick(6);
    chk("glitch_busy_lo", busy, 0);
    idle(20);
    chk("glitch_pulses", (n_char - c0) + (n_frm - f0) + (n_par - p0), 0);
    chk("glitch_data", data_out, 8'hA5);

    // Framing error: 0x3C with low stop bit, line then held low
    c0 = n_char; f0 = n_frm; p0 = n_par;
    send_frame(8'h3C, gpar(8'h3C), 1'b0, k);
    tick(20);
    chk("frm_busy_low_line", busy, 1);
    chk("frm_pulse", n_frm - f0, 1);
    chk("frm_no_char", n_char - c0, 0);
    chk("frm_no_par", n_par - p0, 0);
    chk("frm_data_kept", data_out, 8'hA5);
    idle(5);
    chk("frm_busy_release", busy, 0);
    idle(10);

`ifdef RECEIVER_PARITY_EN
    // Parity error: 0x01 needs parity 1 (even), send 0
    c0 = n_char; f0 = n_frm; p0 = n_par;
    send_frame(8'h01, 1'b0, 1'b1, k);
    idle(4);
    chk("par_pulse", n_par - p0, 1);
    chk("par_no_char", n_char - c0, 0);
    chk("par_no_frm", n_frm - f0, 0);
    chk("par_data_kept", data_out, 8'hA5);
    idle(10);
`endif

    // Overrun: two characters without acknowledge
    c0 = n_char;
    send_frame(8'h11, gpar(8'h11), 1'b1, k);
    idle(4);
    chk("ovr_first_clear", overrun, 0);
    send_frame(8'h22, gpar(8'h22), 1'b1, k);
    idle(4);
    chk("ovr_chars", n_char - c0, 2);
    chk("ovr_data", data_out, 8'h22);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", data_valid, 1);
    ack();
    chk("ovr_ack_valid", data_valid, 0);
    chk("ovr_ack_flag", overrun, 0);

    // Reset in the middle of 0x55 (during data bit 4), then 0x0F
    c0 = n_char; f0 = n_frm; p0 = n_par;
    bit_for(1'b0);
    for (int i = 0; i < 4; i++) bit_for(((8'h55 >> i) & 8'h01) != 0);
    data_in = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_data", data_out, 0);
    chk("arst_valid", data_valid, 0);
    tick(3);
    rst = 1'b1;
    idle(10);
    send_frame(8'h0F, gpar(8'h0F), 1'b1, k);
    idle(4);
    chk("arst_char_cnt", n_char - c0, 1);
    chk("arst_latency", last_char_cyc, k + 2 + LAT);
    chk("arst_data_0f", data_out, 8'h0F);
    chk("arst_errs", (n_frm - f0) + (n_par - p0), 0);

    // Random frames against the frame-level model
    ack();
    m_do = 8'h0F; m_dv = 1'b0; m_ov = 1'b0;
    for (int n = 0; n < 24; n++) begin
      d        = DB'($urandom);
      bad_par  = (P != 0) && ($urandom_range(0, 5) == 0);
      bad_stop = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 1) == 1) begin
        ack();
        m_dv = 1'b0;
        m_ov = 1'b0;
      end
      c0 = n_char; f0 = n_frm; p0 = n_par;
      send_frame(d, gpar(d) ^ bad_par, !bad_stop, k);
      idle(6);
      good = !bad_stop && !bad_par;
      if (good) begin
        m_ov = m_ov | m_dv;
        m_dv = 1'b1;
        m_do = d;
        chk("rnd_latency", last_char_cyc, k + 2 + LAT);
      end
      chk("rnd_char", n_char - c0, good ? 1 : 0);
      chk("rnd_frm", n_frm - f0, bad_stop ? 1 : 0);
      chk("rnd_par", n_par - p0, (bad_par && !bad_stop) ? 1 : 0);
      chk("rnd_data", data_out, m_do);
      chk("rnd_valid", data_valid, m_dv);
      chk("rnd_ovr", overrun, m_ov);
      chk("rnd_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/receiver_param.md
RECEIVER_PARAM -- requirements
Module: receiver_param

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 Parameter OVERSAMPLE, default 16, clk cycles per bit period (even, legal 8..64).
REQ-003 Parameter PARITY_ODD, default 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
REQ-004 Port clk, input, 1, single clock running at OVERSAMPLE x baud rate; all logic on its rising edge.
REQ-005 Port rst, input, 1, reset: asynchronous, active-low.
REQ-006 Port data_in, input, 1, asynchronous serial line, idle high.
REQ-007 Port read_ack, input, 1, consumer pulse acknowledging data_out.
REQ-008 Port data_out, output, DATA_BITS, last good character, LSB received first.
REQ-009 Port character_received, output, 1, one-cycle pulse per good character.
REQ-010 Port data_valid, output, 1, high from character_received until read_ack.
REQ-011 Port framing_error, output, 1, one-cycle pulse on bad stop bit.
REQ-012 Port parity_error, output, 1, one-cycle pulse on parity mismatch.
REQ-013 Port overrun, output, 1, sticky flag: good character completed while data_valid high.
REQ-014 Port busy, output, 1, high in every state except IDLE.

Function
REQ-015 data_in passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-016 FSM states: IDLE, START, DATA, PARITY (only with parity compiled in), STOP, WAIT_IDLE.
REQ-017 IDLE -> START on rx_s falling edge; bit timer cleared to 0 on that cycle.
REQ-018 START: at timer = OVERSAMPLE/2-1: rx_s low -> DATA (timer cleared); rx_s high -> IDLE (glitch rejected, no outputs).
REQ-019 DATA: sample rx_s each time timer = OVERSAMPLE-1; shift in LSB-first; after DATA_BITS samples -> PARITY or STOP.
REQ-020 PARITY: one sample at timer = OVERSAMPLE-1; mismatch against XOR of data bits (inverted if PARITY_ODD) latched as pending error; -> STOP.
REQ-021 STOP: sample at timer = OVERSAMPLE-1; high and no parity error -> load data_out, pulse character_received next cycle, -> IDLE.
REQ-022 STOP sample high with parity error -> pulse parity_error, data_out unchanged, -> IDLE.
REQ-023 STOP sample low -> pulse framing_error (parity_error suppressed), data_out unchanged, -> WAIT_IDLE; leave WAIT_IDLE only when rx_s high.
REQ-024 Latency: character_received asserts OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1+P) + 1 cycles after the IDLE->START edge, P = 1 with parity compiled in, else 0.
REQ-025 read_ack clears data_valid and overrun; read_ack coincident with character_received leaves data_valid high and overrun unchanged (new data wins).
REQ-026 Good character with data_valid high and no same-cycle read_ack: data_out overwritten, overrun set.
REQ-027 Bit timer width is $clog2(OVERSAMPLE); bit counter width is $clog2(DATA_BITS+1); neither wraps outside its state.

Reset
REQ-028 rst low forces IDLE, timers 0, synchronizer flops 1, data_out 0, all flag outputs 0, immediately and asynchronously.
REQ-029 rst asserted mid-frame discards the partial character; after release a frame is recognised only from a new falling edge.

Configuration
REQ-030 Macro RECEIVER_PARITY_EN defined: PARITY state and parity check present, frame = start+DATA_BITS+parity+stop.
REQ-031 Macro RECEIVER_PARITY_EN undefined: no PARITY state, PARITY_ODD ignored, parity_error tied 0, frame = start+DATA_BITS+stop.

Structure
REQ-032 Package receiver_pkg holds the state enum and the PARITY_EVEN/PARITY_ODD constants.
REQ-033 Sub-module rx_bit_timer (clear, mid-point tick, full-bit tick) parametrised by OVERSAMPLE; the rest stays in receiver_param.

Verification (OVERSAMPLE=16, DATA_BITS=8)
REQ-034 No parity, send 0xA5 with valid stop -> data_out=0xA5, character_received one pulse 153 cycles after edge detect, data_valid high.
REQ-035 Hold data_in low 5 cycles then high -> back to IDLE, no pulses, busy low again within 9 cycles of edge detect.
REQ-036 Send 0x3C with stop bit 0 -> framing_error one pulse, data_out keeps prior value, busy high until line returns high.
REQ-037 Parity build, PARITY_ODD=0, send 0x01 with parity bit 0 -> parity_error one pulse, no character_received.
REQ-038 Send 0x11 then 0x22 without read_ack -> data_out=0x22, overrun=1; read_ack -> data_valid=0, overrun=0.
REQ-039 Assert rst at data bit 4 of 0x55, release, send 0x0F -> only 0x0F reported, no error pulses.
